// File: rtl/sensor_slot_scheduler.sv
// rtl/sensor_slot_scheduler.sv - tick-aligned round-robin scheduler for a shared slow sensor bus
module sensor_slot_scheduler #(
    parameter int unsigned TICK_DIV      = 10,
    parameter int unsigned TIMEOUT_TICKS = 200
) (
    input  logic       CLK_1MHZ_IN,
    input  logic       RESET_N,
    input  logic [3:0] REQ_IN,
    input  logic       DONE_IN,
    output logic       TICK_OUT,
    output logic [3:0] GRANT_OUT,
    output logic       BUSY_OUT,
    output logic [1:0] OWNER_ID_OUT,
    output logic       TIMEOUT_OUT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT_TICKS - 1);

    state_t      state_q, state_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic        tick_q, tick_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;

    logic        win_found;
    logic [1:0]  win_id;
    logic [1:0]  cand;

    always_comb begin
        tick_d     = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_d ? 16'd0 : tick_cnt_q + 16'd1;
    end

    // Search starts just past the last owner so every requester gets its turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = ptr_q;
        cand      = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && REQ_IN[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_q && win_found) begin
                    grant_d  = 4'b0001 << win_id;
                    owner_d  = win_id;
                    ptr_d    = win_id;
                    to_cnt_d = 8'd0;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (tick_q && to_cnt_q != 8'hFF) begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
                if (DONE_IN || !REQ_IN[owner_q]) begin
                    grant_d = 4'b0000;
                    state_d = ST_RELEASE;
                end else if (tick_q && to_cnt_q == TO_LAST) begin
                    grant_d   = 4'b0000;
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = 4'b0000;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_1MHZ_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= 16'd0;
            tick_q     <= 1'b0;
            grant_q    <= 4'b0000;
            owner_q    <= 2'd0;
            ptr_q      <= 2'd3;
            to_cnt_q   <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign TICK_OUT     = tick_q;
    assign GRANT_OUT    = grant_q;
    assign BUSY_OUT     = (state_q != ST_IDLE);
    assign OWNER_ID_OUT = owner_q;
    assign TIMEOUT_OUT  = timeout_q;

endmodule
